// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: shared fetch/decode types for the instruction queue.
// Provides addr_t, i32, ecode_t, exception codes, iq_entry_t and IQ_DEPTH.
package instr_queue_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] i32;
  typedef logic [4:0]  ecode_t;

  localparam ecode_t EX_INT  = 5'h00;
  localparam ecode_t EX_ADEL = 5'h04;

  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    addr_t  pc;
    i32     instr;
    logic   exc;
    ecode_t exccode;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// instr_queue: fetch->decode FIFO, first-word fall-through, flush on redirect.
// Ports: clk/reset, flush, in_* push handshake, out_* pop handshake, count.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  addr_t                  in_pc,
  input  i32                     in_instr,
  input  logic                   in_exc,
  input  ecode_t                 in_exccode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output addr_t                  out_pc,
  output i32                     out_instr,
  output logic                   out_exc,
  output ecode_t                 out_exccode,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t         mem_q [DEPTH];
  iq_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              lock_q, lock_d;

  logic              push;
  logic              pop;
  iq_entry_t         in_entry;
  iq_entry_t         head_entry;

  always_comb begin
    in_entry = '{
      pc:      in_pc,
      instr:   in_instr,
      exc:     in_exc,
      exccode: in_exccode
    };
    // Full blocks a push even if a pop frees a slot this cycle.
    // A queued fault blocks everything behind it until redirect.
    in_ready  = (count_q != CW'(DEPTH)) && !lock_q && !flush;
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    lock_d  = lock_q;
    if (flush) begin
      // Storage is left as-is; only pointers are rewound.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      lock_d  = 1'b0;
    end else begin
      if (push) begin
        mem_d[tail_q] = in_entry;
        tail_d        = tail_q + 1'b1;
        if (in_exc) begin
          lock_d = 1'b1;
        end
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    head_entry  = mem_q[head_q];
    out_pc      = head_entry.pc;
    out_instr   = head_entry.instr;
    out_exc     = head_entry.exc;
    out_exccode = head_entry.exccode;
    count       = count_q;
  end

endmodule
